regfile_read_arbiter: RTL

- Shares the single 32-entry x 32-bit register-file read mux between NREQ requesters. Typical requesters are operand fetch A, operand fetch B, debug and trap.
- Round-robin arbitration, one grant per cycle; drives the mux 5-bit select and registers the mux output.
- Returns data to the winning requester with a one-cycle ack pulse.
- Sits between the decode/issue logic and the register-file read mux.

---
 rtl/regfile_read_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares the register-file read mux between NREQ requesters.
// Latency: req sampled in cycle t -> ack/rdata in cycle t+2. Backpressure: hold stalls new grants only.
// Optional RF_ZERO_REG_EN: a read of register 0 returns zero instead of the mux output.
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic               hold,
    output logic [AW-1:0]      sel,
    input  logic [DW-1:0]      mux_data,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [IDW-1:0]     ack_id,
    output logic               busy
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  s1_id;
    logic            s1_vld;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] elig;
    logic            win_vld;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  ptr_nxt;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   cap_data;
    logic            grant;
    int              idx;

    // A requester is masked while its data is in flight or being acked.
    always_comb begin
        mask    = ack | (s1_vld ? (NREQ'(1) << s1_id) : '0);
        elig    = req & ~mask;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
        win_addr = addr[int'(win_id)*AW +: AW];
        ptr_nxt  = (int'(win_id) == NREQ-1) ? '0 : win_id + IDW'(1);
    end

    assign grant = win_vld && !hold;

`ifdef RF_ZERO_REG_EN
    assign cap_data = (sel == '0) ? '0 : mux_data;
`else
    assign cap_data = mux_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sel    <= '0;
            ack    <= '0;
            rdata  <= '0;
            ack_id <= '0;
            ptr    <= '0;
            s1_id  <= '0;
            s1_vld <= 1'b0;
        end else begin
            ack    <= s1_vld ? (NREQ'(1) << s1_id) : '0;
            if (s1_vld) begin
                rdata  <= cap_data;
                ack_id <= s1_id;
            end
            s1_vld <= grant;
            if (grant) begin
                sel   <= win_addr;
                s1_id <= win_id;
                ptr   <= ptr_nxt;
            end
        end
    end

    assign busy = s1_vld;

endmodule
